// File: rtl/host_mailbox_arbiter.sv
// host_mailbox_arbiter
//   Host<->FPGA mailbox front end. Waits in IDLE for the host to write START_CODE
//   into the flag word, acknowledges it, then round-robin arbitrates NCH compute
//   channels onto a single SRAM port. Once every channel has pulsed ch_done it
//   writes DONE_CODE to the flag word DONE_REPEAT times and returns to IDLE.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_flag                             host flag word (only looked at in IDLE)
//   flag_we, out_flag                   flag word write strobe / data
//   mem_rd_req, mem_wr_en, mem_addr     SRAM command (one-cycle strobes)
//   mem_wr_data, mem_rd_data            SRAM data (byte-swapped when SWAP_BYTES=1)
//   mem_rd_ready                        SRAM read data valid
//   ch_req, ch_wr, ch_addr, ch_wdata    per-channel request bundle (packed by channel)
//   ch_done                             per-channel completion pulse
//   ch_grant, ch_rvalid, ch_rdata       grant / read-return to channels
//   ready_2_start, busy, err            status (err is a sticky read timeout)
module host_mailbox_arbiter #(
  parameter int unsigned     NCH         = 4,
  parameter int unsigned     AW          = 21,
  parameter int unsigned     DW          = 32,
  parameter bit              SWAP_BYTES  = 1'b1,
  parameter logic [DW-1:0]   START_CODE  = 32'h0001_0000,
  parameter logic [DW-1:0]   ACK_CODE    = 32'h0000_0002,
  parameter logic [DW-1:0]   DONE_CODE   = 32'h0000_0004,
  parameter logic [AW-1:0]   FLAG_ADDR   = 21'h07FFFE,
  parameter int unsigned     DONE_REPEAT = 3,
  parameter int unsigned     RD_TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     in_flag,
  output logic              flag_we,
  output logic [DW-1:0]     out_flag,
  output logic              mem_rd_req,
  output logic              mem_wr_en,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wr_data,
  input  logic [DW-1:0]     mem_rd_data,
  input  logic              mem_rd_ready,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_wr,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_wdata,
  input  logic [NCH-1:0]    ch_done,
  output logic [NCH-1:0]    ch_grant,
  output logic [NCH-1:0]    ch_rvalid,
  output logic [DW-1:0]     ch_rdata,
  output logic              ready_2_start,
  output logic              busy,
  output logic              err
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned TW = (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;
  localparam int unsigned RW = $clog2(DONE_REPEAT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACK     = 3'd1,
    S_RUN     = 3'd2,
    S_RD_WAIT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    rr_ptr, rr_ptr_nxt;
  logic [PW-1:0]    rd_ch, rd_ch_nxt;
  logic [NCH-1:0]   done_mask, done_mask_nxt;
  logic [TW-1:0]    to_cnt, to_cnt_nxt;
  logic [RW-1:0]    rep_cnt, rep_cnt_nxt;

  logic             flag_we_nxt, mem_rd_req_nxt, mem_wr_en_nxt;
  logic [DW-1:0]    out_flag_nxt, mem_wr_data_nxt, ch_rdata_nxt;
  logic [AW-1:0]    mem_addr_nxt;
  logic [NCH-1:0]   ch_grant_nxt, ch_rvalid_nxt;
  logic             ready_nxt, busy_nxt, err_nxt;

  // Arbiter results
  logic             found;
  logic [PW-1:0]    pick;
  logic [NCH-1:0]   req_eff;
  int unsigned      idx;

  // Per-channel views of the packed request buses
  logic [AW-1:0]    addr_a  [NCH];
  logic [DW-1:0]    wdata_a [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign addr_a[g]  = ch_addr[g*AW +: AW];
    assign wdata_a[g] = ch_wdata[g*DW +: DW];
  end

  // Byte-order reversal on the memory side of the data paths
  function automatic logic [DW-1:0] swap(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (SWAP_BYTES) begin
      for (int unsigned b = 0; b < NB; b++) r[b*8 +: 8] = d[(NB-1-b)*8 +: 8];
    end
    return r;
  endfunction

  // Round-robin pick. A channel currently seeing its grant is masked: it is
  // still holding the request that was just served.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    idx     = 0;
    req_eff = ch_req & ~ch_grant;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = (32'(rr_ptr) + k) % NCH;
      if (!found && req_eff[PW'(idx)]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt       = state;
    rr_ptr_nxt      = rr_ptr;
    rd_ch_nxt       = rd_ch;
    done_mask_nxt   = (state == S_IDLE) ? done_mask : (done_mask | ch_done);
    to_cnt_nxt      = to_cnt;
    rep_cnt_nxt     = rep_cnt;
    flag_we_nxt     = 1'b0;
    out_flag_nxt    = '0;
    mem_rd_req_nxt  = 1'b0;
    mem_wr_en_nxt   = 1'b0;
    mem_addr_nxt    = mem_addr;
    mem_wr_data_nxt = mem_wr_data;
    ch_grant_nxt    = '0;
    ch_rvalid_nxt   = '0;
    ch_rdata_nxt    = ch_rdata;
    err_nxt         = err;

    case (state)
      S_IDLE: begin
        if (in_flag == START_CODE) begin
          state_nxt     = S_ACK;
          done_mask_nxt = '0;
          flag_we_nxt   = 1'b1;
          out_flag_nxt  = ACK_CODE;
          mem_addr_nxt  = FLAG_ADDR;
        end
      end

      S_ACK: state_nxt = S_RUN;

      S_RUN: begin
        // Finish only once the last write strobe has left the port
        if ((&done_mask) && !mem_wr_en) begin
          state_nxt    = S_DONE;
          rep_cnt_nxt  = '0;
          flag_we_nxt  = 1'b1;
          out_flag_nxt = DONE_CODE;
          mem_addr_nxt = FLAG_ADDR;
        end else if (found) begin
          ch_grant_nxt = NCH'(1) << pick;
          rr_ptr_nxt   = (pick == PW'(NCH - 1)) ? '0 : pick + PW'(1);
          mem_addr_nxt = addr_a[pick];
          if (ch_wr[pick]) begin
            mem_wr_en_nxt   = 1'b1;
            mem_wr_data_nxt = swap(wdata_a[pick]);
          end else begin
            mem_rd_req_nxt = 1'b1;
            rd_ch_nxt      = pick;
            to_cnt_nxt     = '0;
            state_nxt      = S_RD_WAIT;
          end
        end
      end

      S_RD_WAIT: begin
        if (mem_rd_ready) begin
          ch_rvalid_nxt = NCH'(1) << rd_ch;
          ch_rdata_nxt  = swap(mem_rd_data);
          state_nxt     = S_RUN;
        end else if (to_cnt == TW'(RD_TIMEOUT)) begin
          err_nxt       = 1'b1;
          ch_rvalid_nxt = NCH'(1) << rd_ch;
          ch_rdata_nxt  = '0;
          state_nxt     = S_RUN;
        end else if (to_cnt != '1) begin
          to_cnt_nxt = to_cnt + TW'(1);
        end
      end

      S_DONE: begin
        if (rep_cnt == RW'(DONE_REPEAT - 1)) begin
          state_nxt = S_IDLE;
        end else begin
          rep_cnt_nxt  = rep_cnt + RW'(1);
          flag_we_nxt  = 1'b1;
          out_flag_nxt = DONE_CODE;
          mem_addr_nxt = FLAG_ADDR;
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    busy_nxt  = (state_nxt != S_IDLE);
    ready_nxt = (state_nxt == S_RUN) || (state_nxt == S_RD_WAIT);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      rd_ch         <= '0;
      done_mask     <= '0;
      to_cnt        <= '0;
      rep_cnt       <= '0;
      flag_we       <= 1'b0;
      out_flag      <= '0;
      mem_rd_req    <= 1'b0;
      mem_wr_en     <= 1'b0;
      mem_addr      <= '0;
      mem_wr_data   <= '0;
      ch_grant      <= '0;
      ch_rvalid     <= '0;
      ch_rdata      <= '0;
      ready_2_start <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_nxt;
      rr_ptr        <= rr_ptr_nxt;
      rd_ch         <= rd_ch_nxt;
      done_mask     <= done_mask_nxt;
      to_cnt        <= to_cnt_nxt;
      rep_cnt       <= rep_cnt_nxt;
      flag_we       <= flag_we_nxt;
      out_flag      <= out_flag_nxt;
      mem_rd_req    <= mem_rd_req_nxt;
      mem_wr_en     <= mem_wr_en_nxt;
      mem_addr      <= mem_addr_nxt;
      mem_wr_data   <= mem_wr_data_nxt;
      ch_grant      <= ch_grant_nxt;
      ch_rvalid     <= ch_rvalid_nxt;
      ch_rdata      <= ch_rdata_nxt;
      ready_2_start <= ready_nxt;
      busy          <= busy_nxt;
      err           <= err_nxt;
    end
  end

endmodule

// File: tb/tb_host_mailbox_arbiter.sv
// Directed bench for host_mailbox_arbiter (default parameters: NCH=4, AW=21, DW=32).
// Inputs change 1 ns after the rising edge; outputs are checked at that point too.
module tb_host_mailbox_arbiter;

  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 21;
  localparam int unsigned DW  = 32;

  logic              clk;
  logic              rst_n;
  logic [DW-1:0]     in_flag;
  logic              flag_we;
  logic [DW-1:0]     out_flag;
  logic              mem_rd_req;
  logic              mem_wr_en;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wr_data;
  logic [DW-1:0]     mem_rd_data;
  logic              mem_rd_ready;
  logic [NCH-1:0]    ch_req;
  logic [NCH-1:0]    ch_wr;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_wdata;
  logic [NCH-1:0]    ch_done;
  logic [NCH-1:0]    ch_grant;
  logic [NCH-1:0]    ch_rvalid;
  logic [DW-1:0]     ch_rdata;
  logic              ready_2_start;
  logic              busy;
  logic              err;

  int vectors = 0;
  int errors  = 0;
  int lat;

  host_mailbox_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_flag      (in_flag),
    .flag_we      (flag_we),
    .out_flag     (out_flag),
    .mem_rd_req   (mem_rd_req),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_ready (mem_rd_ready),
    .ch_req       (ch_req),
    .ch_wr        (ch_wr),
    .ch_addr      (ch_addr),
    .ch_wdata     (ch_wdata),
    .ch_done      (ch_done),
    .ch_grant     (ch_grant),
    .ch_rvalid    (ch_rvalid),
    .ch_rdata     (ch_rdata),
    .ready_2_start(ready_2_start),
    .busy         (busy),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // All outputs at their reset value
  task automatic chk_all_zero(input string tag);
    chk({tag, ".flag_we"},   64'(flag_we),     64'd0);
    chk({tag, ".out_flag"},  64'(out_flag),    64'd0);
    chk({tag, ".rd_req"},    64'(mem_rd_req),  64'd0);
    chk({tag, ".wr_en"},     64'(mem_wr_en),   64'd0);
    chk({tag, ".addr"},      64'(mem_addr),    64'd0);
    chk({tag, ".wr_data"},   64'(mem_wr_data), 64'd0);
    chk({tag, ".grant"},     64'(ch_grant),    64'd0);
    chk({tag, ".rvalid"},    64'(ch_rvalid),   64'd0);
    chk({tag, ".rdata"},     64'(ch_rdata),    64'd0);
    chk({tag, ".ready"},     64'(ready_2_start), 64'd0);
    chk({tag, ".busy"},      64'(busy),        64'd0);
    chk({tag, ".err"},       64'(err),         64'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    in_flag      = '0;
    mem_rd_data  = '0;
    mem_rd_ready = 1'b0;
    ch_req       = '0;
    ch_wr        = '0;
    ch_addr      = '0;
    ch_wdata     = '0;
    ch_done      = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_addr[i*AW +: AW]  = AW'(21'h000100 + i);
      ch_wdata[i*DW +: DW] = 32'h1122_3344 + DW'(i);
    end
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("idle.busy", 64'(busy), 64'd0);

    // 1. Start and acknowledge
    in_flag = 32'h0001_0000;
    tick();
    chk("ack.flag_we",  64'(flag_we),       64'd1);
    chk("ack.out_flag", 64'(out_flag),      64'h2);
    chk("ack.addr",     64'(mem_addr),      64'h07FFFE);
    chk("ack.busy",     64'(busy),          64'd1);
    in_flag = '0;
    tick();
    chk("run.flag_we",  64'(flag_we),       64'd0);
    chk("run.busy",     64'(busy),          64'd1);
    chk("run.ready",    64'(ready_2_start), 64'd1);

    // 2. Four writers held: grants 0,1,2,3,0, strobe every cycle
    ch_req = 4'b1111;
    ch_wr  = 4'b1111;
    tick();
    chk("wr0.grant", 64'(ch_grant),    64'b0001);
    chk("wr0.wr_en", 64'(mem_wr_en),   64'd1);
    chk("wr0.addr",  64'(mem_addr),    64'h000100);
    chk("wr0.data",  64'(mem_wr_data), 64'h4433_2211);
    tick();
    chk("wr1.grant", 64'(ch_grant),    64'b0010);
    chk("wr1.wr_en", 64'(mem_wr_en),   64'd1);
    chk("wr1.addr",  64'(mem_addr),    64'h000101);
    chk("wr1.data",  64'(mem_wr_data), 64'h4533_2211);
    tick();
    chk("wr2.grant", 64'(ch_grant),    64'b0100);
    chk("wr2.wr_en", 64'(mem_wr_en),   64'd1);
    chk("wr2.addr",  64'(mem_addr),    64'h000102);
    tick();
    chk("wr3.grant", 64'(ch_grant),    64'b1000);
    chk("wr3.wr_en", 64'(mem_wr_en),   64'd1);
    chk("wr3.addr",  64'(mem_addr),    64'h000103);
    tick();
    chk("wr4.grant", 64'(ch_grant),    64'b0001);
    chk("wr4.wr_en", 64'(mem_wr_en),   64'd1);
    chk("wr4.addr",  64'(mem_addr),    64'h000100);
    ch_req = '0;
    tick();
    chk("wr_idle.grant", 64'(ch_grant),  64'd0);
    chk("wr_idle.wr_en", 64'(mem_wr_en), 64'd0);

    // 3. Channel 2 read, ready three cycles after the request
    ch_req = 4'b0100;
    ch_wr  = 4'b0000;
    ch_addr[2*AW +: AW] = 21'h03CF96;
    tick();
    chk("rd.grant",  64'(ch_grant),   64'b0100);
    chk("rd.rd_req", 64'(mem_rd_req), 64'd1);
    chk("rd.addr",   64'(mem_addr),   64'h03CF96);
    // Channel 0 asks for a write meanwhile; it must wait for the read
    ch_req = 4'b0001;
    ch_wr  = 4'b0001;
    tick();
    chk("rdw1.grant",  64'(ch_grant),   64'd0);
    chk("rdw1.rd_req", 64'(mem_rd_req), 64'd0);
    tick();
    chk("rdw2.grant",  64'(ch_grant),   64'd0);
    tick();
    chk("rdw3.grant",  64'(ch_grant),   64'd0);
    chk("rdw3.addr",   64'(mem_addr),   64'h03CF96);
    mem_rd_ready = 1'b1;
    mem_rd_data  = 32'hAABB_CCDD;
    tick();
    mem_rd_ready = 1'b0;
    chk("rd.rvalid", 64'(ch_rvalid), 64'b0100);
    chk("rd.rdata",  64'(ch_rdata),  64'hDDCC_BBAA);
    chk("rd.grant0", 64'(ch_grant),  64'd0);
    tick();
    chk("rd.rvalid_off", 64'(ch_rvalid), 64'd0);
    chk("post_rd.grant", 64'(ch_grant),  64'b0001);
    chk("post_rd.wr_en", 64'(mem_wr_en), 64'd1);

    // 4. Channel 1 read that never completes
    ch_req = 4'b0010;
    ch_wr  = 4'b0000;
    tick();
    chk("to.grant",  64'(ch_grant),   64'b0010);
    chk("to.rd_req", 64'(mem_rd_req), 64'd1);
    ch_req = '0;
    // Counter is 0 on the first wait cycle and fires when it holds 255,
    // so rvalid shows 256 cycles after the request cycle.
    lat = 0;
    while (ch_rvalid == '0 && lat < 400) begin
      tick();
      lat++;
    end
    chk("to.latency", 64'(lat),       64'd256);
    chk("to.rvalid",  64'(ch_rvalid), 64'b0010);
    chk("to.rdata",   64'(ch_rdata),  64'd0);
    chk("to.err",     64'(err),       64'd1);
    chk("to.ready",   64'(ready_2_start), 64'd1);

    // 5. Done pulses complete the mask; three done-flag writes follow
    ch_done = 4'b0001;
    tick();
    ch_done = 4'b0110;
    tick();
    ch_done = 4'b1000;
    tick();
    ch_done = '0;
    chk("done.pre_flag", 64'(flag_we), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done.flag_we",  64'(flag_we),       64'd1);
      chk("done.out_flag", 64'(out_flag),      64'h4);
      chk("done.addr",     64'(mem_addr),      64'h07FFFE);
      chk("done.ready",    64'(ready_2_start), 64'd0);
    end
    tick();
    chk("done.end_flag", 64'(flag_we), 64'd0);
    chk("done.busy",     64'(busy),    64'd0);

    // err survives a new start
    in_flag = 32'h0001_0000;
    tick();
    chk("restart.flag_we", 64'(flag_we), 64'd1);
    chk("restart.err",     64'(err),     64'd1);
    in_flag = '0;
    tick();

    // 6. Reset while waiting on a read
    ch_req = 4'b1000;
    ch_wr  = 4'b0000;
    tick();
    chk("rst_rd.grant", 64'(ch_grant), 64'b1000);
    ch_req = '0;
    tick();
    rst_n = 1'b0;
    #2;
    chk_all_zero("async_rst");
    mem_rd_ready = 1'b1;
    mem_rd_data  = 32'h1234_5678;
    tick();
    tick();
    chk("rst.rvalid", 64'(ch_rvalid), 64'd0);
    chk("rst.rdata",  64'(ch_rdata),  64'd0);
    mem_rd_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    in_flag = 32'h0001_0000;
    tick();
    chk("post_rst.flag_we",  64'(flag_we),  64'd1);
    chk("post_rst.out_flag", 64'(out_flag), 64'h2);
    chk("post_rst.err",      64'(err),      64'd0);
    in_flag = '0;
    tick();
    chk("post_rst.ready", 64'(ready_2_start), 64'd1);
    // Pointer is back at 0 after reset
    ch_req = 4'b0011;
    ch_wr  = 4'b0011;
    tick();
    chk("post_rst.grant0", 64'(ch_grant), 64'b0001);
    tick();
    chk("post_rst.grant1", 64'(ch_grant), 64'b0010);
    ch_req = '0;
    tick();
    chk("post_rst.grant_off", 64'(ch_grant), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
